game_controller: RTL and testbench

- Central game FSM of the Orion memory/reaction game.
- Sits between user authentication and the shaped-button path upstream, and the digit sequencer, two-digit countdown timer and player/random-number 7-segment decoders downstream.
- Presents a target digit, compares the player's entered digit, tracks score and level, drives timer reconfigure/enable, and requests logout at game end.

---
 rtl/orion_pkg.sv | 20 ++
 rtl/score_level_tracker.sv | 86 ++++++++
 rtl/game_controller.sv | 176 +++++++++++++++++
 tb/tb_game_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orion_pkg.sv
// Shared types and constants for the Orion game controller slice.
package orion_pkg;

  localparam int LEVEL_W = 2;
  localparam int DIGIT_W = 4;
  localparam int HIT_W   = 4;

  // Value shown on both digit displays before the first digit of a session.
  localparam logic [DIGIT_W-1:0] DISP_IDLE = 4'h0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_SEQ = 3'd2,
    PLAY     = 3'd3,
    CHECK    = 3'd4,
    GAMEOVER = 3'd5
  } state_e;

endpackage

// File: rtl/score_level_tracker.sv
// Score, hit counter and level bookkeeping for the game controller.
// Saturates score at all-ones and level at MAX_LEVEL.
// Build option: MISS_PENALTY_EN makes a miss cost one point (floor 0) and
// clears the consecutive-hit counter; without it a miss changes nothing.
module score_level_tracker
  import orion_pkg::*;
#(
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 3,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               hit_i,
  input  logic               miss_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [HIT_W-1:0]   hit_count_o,
  output logic [LEVEL_W-1:0] game_level_o,
  output logic               level_up_o
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [HIT_W-1:0]   HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [HIT_W-1:0]   hit_count_q, hit_count_d;
  logic [LEVEL_W-1:0] level_q, level_d;

  // Level-up is combinational so the controller can register its timer
  // reload in the same edge that the new level becomes visible.
  assign level_up_o = hit_i && !clear_i && (hit_count_q == HIT_LAST);

  // Next-state bookkeeping: clear wins, then hit, then miss.
  always_comb begin
    score_d     = score_q;
    hit_count_d = hit_count_q;
    level_d     = level_q;
    if (clear_i) begin
      score_d     = '0;
      hit_count_d = '0;
      level_d     = '0;
    end else if (hit_i) begin
      if (score_q != SCORE_MAX) begin
        score_d = score_q + 1'b1;
      end
      if (hit_count_q == HIT_LAST) begin
        hit_count_d = '0;
        if (level_q != LEVEL_MAX) begin
          level_d = level_q + 1'b1;
        end
      end else begin
        hit_count_d = hit_count_q + 1'b1;
      end
    end else if (miss_i) begin
`ifdef MISS_PENALTY_EN
      if (score_q != '0) begin
        score_d = score_q - 1'b1;
      end
      hit_count_d = '0;
`else
      score_d     = score_q;
      hit_count_d = hit_count_q;
`endif
    end
  end

  // Registered score, hit count and level.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q     <= '0;
      hit_count_q <= '0;
      level_q     <= '0;
    end else begin
      score_q     <= score_d;
      hit_count_q <= hit_count_d;
      level_q     <= level_d;
    end
  end

  assign score_o      = score_q;
  assign hit_count_o  = hit_count_q;
  assign game_level_o = level_q;

endmodule

// File: rtl/game_controller.sv
// Central game FSM of the Orion memory/reaction game.
// Requests a target digit, waits for the player's entry, scores it through
// score_level_tracker and drives the countdown timer and logout request.
// Build option: MISS_PENALTY_EN (passed through to score_level_tracker).
//
// Handshake: every interface here is a plain strobe with no back-pressure.
// seq_req, timer_reconfig and gc_logout are one-cycle pulses; seq_valid,
// enter_pulse and pulse_2s are one-cycle pulses that are acted on only in
// the state that expects them and are otherwise dropped.
module game_controller
  import orion_pkg::*;
#(
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 3,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               logged_in,
  input  logic               enter_pulse,
  input  logic [DIGIT_W-1:0] player_digit,
  input  logic [DIGIT_W-1:0] seq_digit,
  input  logic               seq_valid,
  input  logic               timeout,
  input  logic               pulse_2s,
  output logic               seq_req,
  output logic               timer_reconfig,
  output logic               timer_enable,
  output logic [LEVEL_W-1:0] game_level,
  output logic               gc_logout,
  output logic [DIGIT_W-1:0] player_disp,
  output logic [DIGIT_W-1:0] randnum_disp,
  output logic [SCORE_W-1:0] score,
  output state_e             dbg_state,
  output logic [HIT_W-1:0]   dbg_hit_count
);

  state_e             state_q, state_d;
  logic               seq_req_q, seq_req_d;
  logic               reconfig_q, reconfig_d;
  logic               timer_en_q, timer_en_d;
  logic               logout_q, logout_d;
  logic [DIGIT_W-1:0] player_disp_q, player_disp_d;
  logic [DIGIT_W-1:0] rand_disp_q, rand_disp_d;

  logic               trk_clear;
  logic               trk_hit;
  logic               trk_miss;
  logic               trk_level_up;

  score_level_tracker #(
    .HITS_PER_LEVEL (HITS_PER_LEVEL),
    .MAX_LEVEL      (MAX_LEVEL),
    .SCORE_W        (SCORE_W)
  ) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (trk_clear),
    .hit_i        (trk_hit),
    .miss_i       (trk_miss),
    .score_o      (score),
    .hit_count_o  (dbg_hit_count),
    .game_level_o (game_level),
    .level_up_o   (trk_level_up)
  );

  // Next-state and registered-output decode. A logout in any active state
  // beats everything else; timeout beats a same-cycle entry or check.
  always_comb begin
    state_d       = state_q;
    seq_req_d     = 1'b0;
    reconfig_d    = 1'b0;
    logout_d      = 1'b0;
    timer_en_d    = timer_en_q;
    player_disp_d = player_disp_q;
    rand_disp_d   = rand_disp_q;
    trk_clear     = 1'b0;
    trk_hit       = 1'b0;
    trk_miss      = 1'b0;

    if ((state_q != IDLE) && !logged_in) begin
      state_d    = IDLE;
      timer_en_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_en_d = 1'b0;
          if (logged_in) begin
            trk_clear  = 1'b1;
            reconfig_d = 1'b1;
            state_d    = REQ;
          end
        end
        REQ: begin
          seq_req_d = 1'b1;
          state_d   = WAIT_SEQ;
        end
        WAIT_SEQ: begin
          if (timeout) begin
            timer_en_d = 1'b0;
            state_d    = GAMEOVER;
          end else if (seq_valid) begin
            rand_disp_d = seq_digit;
            timer_en_d  = 1'b1;
            state_d     = PLAY;
          end
        end
        PLAY: begin
          timer_en_d = 1'b1;
          if (timeout) begin
            timer_en_d = 1'b0;
            state_d    = GAMEOVER;
          end else if (enter_pulse) begin
            player_disp_d = player_digit;
            state_d       = CHECK;
          end
        end
        CHECK: begin
          if (timeout) begin
            timer_en_d = 1'b0;
            state_d    = GAMEOVER;
          end else begin
            if (player_disp_q == rand_disp_q) begin
              trk_hit    = 1'b1;
              reconfig_d = trk_level_up;
            end else begin
              trk_miss = 1'b1;
            end
            state_d = REQ;
          end
        end
        GAMEOVER: begin
          timer_en_d = 1'b0;
          if (pulse_2s) begin
            logout_d = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          timer_en_d = 1'b0;
          state_d    = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      seq_req_q     <= 1'b0;
      reconfig_q    <= 1'b0;
      timer_en_q    <= 1'b0;
      logout_q      <= 1'b0;
      player_disp_q <= DISP_IDLE;
      rand_disp_q   <= DISP_IDLE;
    end else begin
      state_q       <= state_d;
      seq_req_q     <= seq_req_d;
      reconfig_q    <= reconfig_d;
      timer_en_q    <= timer_en_d;
      logout_q      <= logout_d;
      player_disp_q <= player_disp_d;
      rand_disp_q   <= rand_disp_d;
    end
  end

  assign seq_req        = seq_req_q;
  assign timer_reconfig = reconfig_q;
  assign timer_enable   = timer_en_q;
  assign gc_logout      = logout_q;
  assign player_disp    = player_disp_q;
  assign randnum_disp   = rand_disp_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: a per-cycle vector table followed by
// hand-written sequences for levelling, misses, saturation and reset.
module tb_game_controller;
  import orion_pkg::*;

  logic       clk;
  logic       rst;
  logic       logged_in;
  logic       enter_pulse;
  logic [3:0] player_digit;
  logic [3:0] seq_digit;
  logic       seq_valid;
  logic       timeout;
  logic       pulse_2s;
  logic       seq_req;
  logic       timer_reconfig;
  logic       timer_enable;
  logic [1:0] game_level;
  logic       gc_logout;
  logic [3:0] player_disp;
  logic [3:0] randnum_disp;
  logic [7:0] score;
  state_e     dbg_state;
  logic [3:0] dbg_hit_count;

  int tests_run;
  int tests_failed;

  game_controller dut (
    .clk            (clk),
    .rst            (rst),
    .logged_in      (logged_in),
    .enter_pulse    (enter_pulse),
    .player_digit   (player_digit),
    .seq_digit      (seq_digit),
    .seq_valid      (seq_valid),
    .timeout        (timeout),
    .pulse_2s       (pulse_2s),
    .seq_req        (seq_req),
    .timer_reconfig (timer_reconfig),
    .timer_enable   (timer_enable),
    .game_level     (game_level),
    .gc_logout      (gc_logout),
    .player_disp    (player_disp),
    .randnum_disp   (randnum_disp),
    .score          (score),
    .dbg_state      (dbg_state),
    .dbg_hit_count  (dbg_hit_count)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       li;
    logic       en;
    logic [3:0] pd;
    logic [3:0] sd;
    logic       sv;
    logic       to;
    logic       p2;
    state_e     st;
    logic       sr;
    logic       rc;
    logic       te;
    logic [1:0] lv;
    logic       lo;
    logic [3:0] pdisp;
    logic [3:0] rdisp;
    logic [7:0] sc;
  } vec_t;

  vec_t vecs[$];

  // Score after the miss in the table (target 5, entry 3, from score 1).
`ifdef MISS_PENALTY_EN
  localparam logic [7:0] MISS_SC = 8'd0;
`else
  localparam logic [7:0] MISS_SC = 8'd1;
`endif

  function automatic void add(input logic li, en, input logic [3:0] pd, sd,
                              input logic sv, to, p2, input state_e st,
                              input logic sr, rc, te, input logic [1:0] lv,
                              input logic lo, input logic [3:0] pdisp, rdisp,
                              input logic [7:0] sc);
    vec_t v;
    v.li = li; v.en = en; v.pd = pd; v.sd = sd; v.sv = sv; v.to = to; v.p2 = p2;
    v.st = st; v.sr = sr; v.rc = rc; v.te = te; v.lv = lv; v.lo = lo;
    v.pdisp = pdisp; v.rdisp = rdisp; v.sc = sc;
    vecs.push_back(v);
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enter_pulse  = 1'b0;
    seq_valid    = 1'b0;
    timeout      = 1'b0;
    pulse_2s     = 1'b0;
    player_digit = 4'h0;
    seq_digit    = 4'h0;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {7'd0, dbg_state, seq_req, timer_reconfig, timer_enable, game_level,
            gc_logout, player_disp, randnum_disp, score};
  endfunction

  // One full digit round starting and ending with the FSM in REQ.
  task automatic play_round(input logic [3:0] tgt, input logic [3:0] ent,
                            output logic rc, output logic [7:0] sc,
                            output logic [1:0] lv);
    step();
    seq_valid = 1'b1; seq_digit = tgt;
    step();
    seq_valid = 1'b0;
    enter_pulse = 1'b1; player_digit = ent;
    step();
    enter_pulse = 1'b0;
    step();
    chk("round_ends_in_req", 32'(dbg_state), 32'(REQ));
    rc = timer_reconfig;
    sc = score;
    lv = game_level;
  endtask

  initial begin
    logic       rc;
    logic [7:0] sc;
    logic [1:0] lv;
    int         exp_lv;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    logged_in    = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    chk("reset_outputs", pack_out(), {7'd0, IDLE, 22'd0});

    //   li en pd  sd  sv to p2  state     sr rc te lv lo pdisp rdisp score
    add(1, 0, 0,  0,  0, 0, 0, REQ,      0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,  0,  0, 0, 0, WAIT_SEQ, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,  7,  1, 0, 0, PLAY,     0, 0, 1, 0, 0, 0, 7, 0);
    add(1, 1, 7,  0,  0, 0, 0, CHECK,    0, 0, 1, 0, 0, 7, 7, 0);
    add(1, 0, 0,  0,  0, 0, 0, REQ,      0, 0, 1, 0, 0, 7, 7, 1);
    add(1, 0, 0,  0,  0, 0, 0, WAIT_SEQ, 1, 0, 1, 0, 0, 7, 7, 1);
    add(1, 1, 5,  0,  0, 0, 0, WAIT_SEQ, 0, 0, 1, 0, 0, 7, 7, 1);
    add(1, 0, 0,  5,  1, 0, 0, PLAY,     0, 0, 1, 0, 0, 7, 5, 1);
    add(1, 0, 0,  9,  1, 0, 0, PLAY,     0, 0, 1, 0, 0, 7, 5, 1);
    add(1, 1, 3,  0,  0, 0, 0, CHECK,    0, 0, 1, 0, 0, 3, 5, 1);
    add(1, 0, 0,  0,  0, 0, 0, REQ,      0, 0, 1, 0, 0, 3, 5, MISS_SC);
    add(1, 0, 0,  0,  0, 0, 0, WAIT_SEQ, 1, 0, 1, 0, 0, 3, 5, MISS_SC);
    add(1, 0, 0,  5,  1, 0, 0, PLAY,     0, 0, 1, 0, 0, 3, 5, MISS_SC);
    add(1, 1, 5,  0,  0, 1, 0, GAMEOVER, 0, 0, 0, 0, 0, 3, 5, MISS_SC);
    add(1, 0, 0,  0,  0, 0, 0, GAMEOVER, 0, 0, 0, 0, 0, 3, 5, MISS_SC);
    add(1, 0, 0,  0,  0, 0, 1, IDLE,     0, 0, 0, 0, 1, 3, 5, MISS_SC);
    add(0, 0, 0,  0,  0, 0, 0, IDLE,     0, 0, 0, 0, 0, 3, 5, MISS_SC);
    add(1, 0, 0,  0,  0, 0, 0, REQ,      0, 1, 0, 0, 0, 3, 5, 0);
    add(1, 0, 0,  0,  0, 0, 0, WAIT_SEQ, 1, 0, 0, 0, 0, 3, 5, 0);
    add(0, 0, 0,  0,  0, 0, 0, IDLE,     0, 0, 0, 0, 0, 3, 5, 0);

    foreach (vecs[i]) begin
      logged_in    = vecs[i].li;
      enter_pulse  = vecs[i].en;
      player_digit = vecs[i].pd;
      seq_digit    = vecs[i].sd;
      seq_valid    = vecs[i].sv;
      timeout      = vecs[i].to;
      pulse_2s     = vecs[i].p2;
      step();
      chk($sformatf("vec%0d", i), pack_out(),
          {7'd0, vecs[i].st, vecs[i].sr, vecs[i].rc, vecs[i].te, vecs[i].lv,
           vecs[i].lo, vecs[i].pdisp, vecs[i].rdisp, vecs[i].sc});
    end
    idle_inputs();

    // Sixteen straight hits: level steps every fourth hit and saturates at 3,
    // but the timer reload keeps pulsing on every fourth hit.
    logged_in = 1'b1;
    step();
    chk("login_reconfig", 32'(timer_reconfig), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      play_round(4'd2, 4'd2, rc, sc, lv);
      exp_lv = (i / 4 > 3) ? 3 : i / 4;
      chk($sformatf("lvl_reconfig_hit%0d", i), 32'(rc), 32'((i % 4) == 0));
      chk($sformatf("lvl_level_hit%0d", i), 32'(lv), 32'(exp_lv));
      chk($sformatf("lvl_score_hit%0d", i), 32'(sc), 32'(i));
    end

    // Logout while waiting for a digit with the countdown running.
    step();
    chk("drop_pre_state", 32'(dbg_state), 32'(WAIT_SEQ));
    chk("drop_pre_enable", 32'(timer_enable), 32'd1);
    logged_in = 1'b0;
    step();
    chk("drop_state", 32'(dbg_state), 32'(IDLE));
    chk("drop_enable", 32'(timer_enable), 32'd0);
    chk("drop_no_logout", 32'(gc_logout), 32'd0);
    chk("drop_score_held", 32'(score), 32'd16);
    chk("drop_level_held", 32'(game_level), 32'd3);
    logged_in = 1'b1;
    step();
    chk("relogin_score", 32'(score), 32'd0);
    chk("relogin_level", 32'(game_level), 32'd0);

    // Two hits, one miss, then two more hits.
    play_round(4'd5, 4'd5, rc, sc, lv);
    play_round(4'd5, 4'd5, rc, sc, lv);
    chk("miss_pre_score", 32'(sc), 32'd2);
    play_round(4'd5, 4'd3, rc, sc, lv);
`ifdef MISS_PENALTY_EN
    chk("miss_score", 32'(sc), 32'd1);
    chk("miss_hits", 32'(dbg_hit_count), 32'd0);
`else
    chk("miss_score", 32'(sc), 32'd2);
    chk("miss_hits", 32'(dbg_hit_count), 32'd2);
`endif
    play_round(4'd5, 4'd5, rc, sc, lv);
    play_round(4'd5, 4'd5, rc, sc, lv);
`ifdef MISS_PENALTY_EN
    chk("post_miss_level", 32'(lv), 32'd0);
    chk("post_miss_score", 32'(sc), 32'd3);
`else
    chk("post_miss_level", 32'(lv), 32'd1);
    chk("post_miss_score", 32'(sc), 32'd4);
`endif

    // Misses starting from a zero score never go below zero.
    logged_in = 1'b0;
    step();
    logged_in = 1'b1;
    step();
    play_round(4'd5, 4'd3, rc, sc, lv);
    chk("zero_miss1", 32'(sc), 32'd0);
    play_round(4'd5, 4'd3, rc, sc, lv);
    chk("zero_miss2", 32'(sc), 32'd0);

    // Score saturates at all-ones.
    for (int i = 0; i < 260; i++) begin
      play_round(4'd9, 4'd9, rc, sc, lv);
      if (i == 254) chk("sat_score_255", 32'(sc), 32'd255);
    end
    chk("sat_score_hold", 32'(sc), 32'd255);
    chk("sat_level", 32'(lv), 32'd3);

    // Synchronous reset taken in the middle of PLAY.
    step();
    seq_valid = 1'b1; seq_digit = 4'd4;
    step();
    seq_valid = 1'b0;
    chk("rst_pre_state", 32'(dbg_state), 32'(PLAY));
    rst = 1'b1;
    step();
    rst = 1'b0;
    logged_in = 1'b0;
    chk("rst_mid_play", pack_out(), {7'd0, IDLE, 22'd0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
